// File: rtl/buffered_write_pkg.sv
`default_nettype none
// ============================================================================
// Module   : buffered_write_pkg
// Purpose  : Shared types and constants for the buffered write stage.
//            It holds the default configuration, the register value and
//            register file types, the store entry layout, and the fixed
//            register indices and flag-field position.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package buffered_write_pkg;

  // Default configuration of the write stage.
  localparam int BW_DEF_NR        = 16;
  localparam int BW_DEF_WIDTH     = 32;
  localparam int BW_DEF_DEPTH     = 4;
  localparam int BW_DEF_FLAGS_IDX = 14;
  localparam int BW_DEF_PC_IDX    = 15;

  // r0 always reads as zero.
  localparam int R0_IDX = 0;

  // Position of the condition flags inside the Flags register.
  localparam int FLAG_LSB = 27;
  localparam int FLAG_MSB = 30;

  typedef logic [BW_DEF_WIDTH-1:0]           regval_t;
  typedef logic [BW_DEF_NR*BW_DEF_WIDTH-1:0] regfile_t;

  typedef struct packed {
    regval_t addr;
    regval_t data;
  } store_entry_t;

endpackage : buffered_write_pkg
`default_nettype wire

// File: rtl/buffered_write_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : buffered_write_store_buffer
// Purpose  : In-order circular store buffer that sits between the write stage
//            and the memory port. The head entry is presented on o_req,
//            o_addr and o_data. It is popped on o_req && i_ack.
// Macro    : WRITE_COMBINE_EN - when defined, o_match reports that i_addr
//            equals the tail entry's address while at least two entries are
//            held. A push that matches overwrites the tail data and does not
//            allocate a new entry.
// Ports    : clk, rst            clock / synchronous active-high reset
//            i_push              store accepted this cycle
//            i_addr, i_data      store address / data to push
//            i_ack               memory accepted the head request
//            o_req               head entry valid
//            o_addr, o_data      head entry
//            o_full, o_empty     occupancy flags
//            o_match             tail-combine match (0 when combining is off)
// Revision : 1.0 - initial release
// ============================================================================
module buffered_write_store_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_addr,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ack,
  output logic             o_req,
  output logic [WIDTH-1:0] o_addr,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_match
);

  localparam int               c_ptr_w      = $clog2(DEPTH);
  localparam logic [c_ptr_w:0] c_full_count = (c_ptr_w+1)'(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t               r_mem [DEPTH];
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w:0]     r_count;

  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_alloc;
  logic                 w_combine;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_full_count);
  // An ack with nothing presented is ignored.
  assign w_pop   = !w_empty && i_ack;

`ifdef WRITE_COMBINE_EN
  localparam logic [c_ptr_w:0] c_two = (c_ptr_w+1)'(2);
  logic [c_ptr_w-1:0] w_tail_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  assign w_tail_ptr = r_wr_ptr - 1'b1;
  // Need two or more entries so the tail is never the head being presented.
  // i_push is left out of the match so that the upstream ready path stays
  // free of combinational loops.
  assign o_match    = (r_count >= c_two) && (r_mem[w_tail_ptr].addr == i_addr);
  assign w_combine  = i_push && o_match;

  always_ff @(posedge clk) begin
    if (w_combine) begin
      r_mem[w_tail_ptr].data <= i_data;
    end
    if (w_alloc) begin
      r_mem[r_wr_ptr] <= '{addr: i_addr, data: i_data};
    end
  end
`else
  assign o_match   = 1'b0;
  assign w_combine = 1'b0;

  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_mem[r_wr_ptr] <= '{addr: i_addr, data: i_data};
    end
  end
`endif

  assign w_alloc = i_push && !w_combine && !w_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_alloc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_alloc, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head entry comes straight from storage. It is stable until it is popped.
  assign o_req   = !w_empty;
  assign o_addr  = r_mem[r_rd_ptr].addr;
  assign o_data  = r_mem[r_rd_ptr].data;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule : buffered_write_store_buffer
`default_nettype wire

// File: rtl/buffered_write.sv
`default_nettype none
// ============================================================================
// Module   : buffered_write
// Purpose  : Pipeline write stage. It retires execute results into the
//            register file and queues memory stores in a store buffer. The
//            pipeline stalls only when a store meets a full buffer.
// Macro    : WRITE_COMBINE_EN - when defined, a store to the tail entry's
//            address merges into that entry. The merge is allowed even when
//            the buffer is full.
// Ports    : clock, reset        clock / synchronous active-high reset
//            in_valid/in_ready   execute result handshake
//            dest_reg/dest_value destination (or store base) and value/data
//            has_upper/upper_value  pair write to dest_reg+1
//            is_store/adjustment store select and address offset
//            flags_in            new flag bits [30:27]
//            pc_in/next_pc       fetch PC and sequential next PC
//            flushed_in/out      flush marker in / registered out
//            regs_in/regs_out    current / registered next register file
//            mem_req/addr/data/ack  store drain port
//            sb_empty            store buffer empty
// Revision : 1.0 - initial release
// ============================================================================
module buffered_write
  import buffered_write_pkg::*;
#(
  parameter int NR        = BW_DEF_NR,
  parameter int WIDTH     = BW_DEF_WIDTH,
  parameter int DEPTH     = BW_DEF_DEPTH,
  parameter int FLAGS_IDX = BW_DEF_FLAGS_IDX,
  parameter int PC_IDX    = BW_DEF_PC_IDX
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [$clog2(NR)-1:0]   dest_reg,
  input  logic [WIDTH-1:0]        dest_value,
  input  logic                    has_upper,
  input  logic [WIDTH-1:0]        upper_value,
  input  logic                    is_store,
  input  logic [WIDTH-1:0]        adjustment,
  input  logic [3:0]              flags_in,
  input  logic [WIDTH-1:0]        pc_in,
  input  logic [WIDTH-1:0]        next_pc,
  input  logic                    flushed_in,
  input  logic [NR*WIDTH-1:0]     regs_in,
  output logic [NR*WIDTH-1:0]     regs_out,
  output logic                    flushed_out,
  output logic                    mem_req,
  output logic [WIDTH-1:0]        mem_addr,
  output logic [WIDTH-1:0]        mem_data,
  input  logic                    mem_ack,
  output logic                    sb_empty
);

  localparam int                   c_idx_w    = $clog2(NR);
  localparam logic [c_idx_w-1:0]   c_pc_idx   = c_idx_w'(PC_IDX);
  localparam logic [c_idx_w:0]     c_pc_idx_x = (c_idx_w+1)'(PC_IDX);
  localparam logic [c_idx_w:0]     c_nr       = (c_idx_w+1)'(NR);

  logic [NR*WIDTH-1:0] r_regs;
  logic                r_flushed;

  logic [NR*WIDTH-1:0] w_regs_d;
  logic [WIDTH-1:0]    w_base;
  logic [WIDTH-1:0]    w_store_addr;
  logic [WIDTH-1:0]    w_flags_merged;
  logic [c_idx_w:0]    w_upper_idx;
  logic                w_upper_ok;
  logic                w_accept;
  logic                w_push;
  logic                w_sb_full;
  logic                w_sb_match;

  // A store that meets a full buffer waits. An ack in the same cycle does
  // not help, because the ready path does not depend on mem_ack. A store
  // that combines into the tail needs no new entry, so it can proceed.
  assign in_ready = !(is_store && w_sb_full && !w_sb_match);
  assign w_accept = in_valid && in_ready;
  assign w_push   = w_accept && is_store;

  // Store base register read. The PC slot reads as the fetch PC of this
  // instruction, not as the stale register file value.
  always_comb begin
    w_base = '0;
    for (int i = 0; i < NR; i++) begin
      if (dest_reg == c_idx_w'(i)) begin
        w_base = regs_in[i*WIDTH +: WIDTH];
      end
    end
    if (dest_reg == c_pc_idx) begin
      w_base = pc_in;
    end
  end

  assign w_store_addr = w_base + adjustment;

  // Widened by one bit so that dest_reg+1 cannot wrap back to r0.
  assign w_upper_idx = {1'b0, dest_reg} + 1'b1;
  assign w_upper_ok  = has_upper && (w_upper_idx < c_nr) &&
                       (w_upper_idx != c_pc_idx_x);

  always_comb begin
    w_flags_merged                    = regs_in[FLAGS_IDX*WIDTH +: WIDTH];
    w_flags_merged[FLAG_MSB:FLAG_LSB] = flags_in;

    w_regs_d = r_regs;
    if (w_accept) begin
      for (int i = 0; i < NR; i++) begin
        if (i == R0_IDX) begin
          w_regs_d[i*WIDTH +: WIDTH] = '0;
        end else if (!is_store && (dest_reg == c_idx_w'(i))) begin
          w_regs_d[i*WIDTH +: WIDTH] = dest_value;
        end else if (!is_store && w_upper_ok &&
                     (w_upper_idx == (c_idx_w+1)'(i))) begin
          w_regs_d[i*WIDTH +: WIDTH] = upper_value;
        end else if (i == FLAGS_IDX) begin
          w_regs_d[i*WIDTH +: WIDTH] = w_flags_merged;
        end else begin
          w_regs_d[i*WIDTH +: WIDTH] = regs_in[i*WIDTH +: WIDTH];
        end
      end
    end

    // The PC advances every cycle, even when nothing is accepted.
    w_regs_d[PC_IDX*WIDTH +: WIDTH] =
      (w_accept && !is_store && (dest_reg == c_pc_idx)) ? dest_value : next_pc;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_regs    <= '0;
      r_flushed <= 1'b0;
    end else begin
      r_regs <= w_regs_d;
      if (w_accept) begin
        r_flushed <= flushed_in;
      end
    end
  end

  assign regs_out    = r_regs;
  assign flushed_out = r_flushed;

  buffered_write_store_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_store_buffer (
    .clk     (clock),
    .rst     (reset),
    .i_push  (w_push),
    .i_addr  (w_store_addr),
    .i_data  (dest_value),
    .i_ack   (mem_ack),
    .o_req   (mem_req),
    .o_addr  (mem_addr),
    .o_data  (mem_data),
    .o_full  (w_sb_full),
    .o_empty (sb_empty),
    .o_match (w_sb_match)
  );

endmodule : buffered_write
`default_nettype wire

// File: tb/tb_buffered_write.sv
`default_nettype none
// ============================================================================
// Module   : tb_buffered_write
// Purpose  : Directed self-checking bench for buffered_write. It uses the
//            default configuration: NR=16, WIDTH=32, DEPTH=4, FLAGS=14, PC=15.
// Revision : 1.0 - initial release
// ============================================================================
module tb_buffered_write;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    dest_reg;
  logic [31:0]   dest_value;
  logic          has_upper;
  logic [31:0]   upper_value;
  logic          is_store;
  logic [31:0]   adjustment;
  logic [3:0]    flags_in;
  logic [31:0]   pc_in;
  logic [31:0]   next_pc;
  logic          flushed_in;
  logic [511:0]  regs_in;
  logic [511:0]  regs_out;
  logic          flushed_out;
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_data;
  logic          mem_ack;
  logic          sb_empty;

  logic [31:0]   rin [16];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  always_comb begin
    for (int i = 0; i < 16; i++) regs_in[i*32 +: 32] = rin[i];
  end

  buffered_write dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dest_reg    (dest_reg),
    .dest_value  (dest_value),
    .has_upper   (has_upper),
    .upper_value (upper_value),
    .is_store    (is_store),
    .adjustment  (adjustment),
    .flags_in    (flags_in),
    .pc_in       (pc_in),
    .next_pc     (next_pc),
    .flushed_in  (flushed_in),
    .regs_in     (regs_in),
    .regs_out    (regs_out),
    .flushed_out (flushed_out),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_ack     (mem_ack),
    .sb_empty    (sb_empty)
  );

  function automatic logic [31:0] rout(int i);
    return regs_out[i*32 +: 32];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_store(input logic [3:0] base, input logic [31:0] adj,
                             input logic [31:0] data);
    in_valid   = 1'b1;
    is_store   = 1'b1;
    has_upper  = 1'b0;
    dest_reg   = base;
    adjustment = adj;
    dest_value = data;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (regs_out !== '0) begin errors++; $display("FAIL reset_regs got %h exp 0", regs_out); end
    checks++; if (flushed_out !== 1'b0) begin errors++; $display("FAIL reset_flushed got %b exp 0", flushed_out); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
    checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL reset_sb_empty got %b exp 1", sb_empty); end
    reset = 1'b0;
  endtask

  task automatic test_alu();
    in_valid = 1'b1; is_store = 1'b0; dest_reg = 4'd3; dest_value = 32'h1234;
    has_upper = 1'b1; upper_value = 32'hABCD; flags_in = 4'b1010;
    next_pc = 32'h80; flushed_in = 1'b1;
    tick();
    checks++; if (rout(3) !== 32'h1234) begin errors++; $display("FAIL alu_r3 got %h exp %h", rout(3), 32'h1234); end
    checks++; if (rout(4) !== 32'hABCD) begin errors++; $display("FAIL alu_r4 got %h exp %h", rout(4), 32'hABCD); end
    checks++; if (rout(0) !== 32'h0) begin errors++; $display("FAIL alu_r0 got %h exp 0", rout(0)); end
    checks++; if (rout(15) !== 32'h80) begin errors++; $display("FAIL alu_pc got %h exp %h", rout(15), 32'h80); end
    checks++; if (rout(14) !== 32'hD7FF_FFFF) begin errors++; $display("FAIL alu_flags got %h exp %h", rout(14), 32'hD7FF_FFFF); end
    checks++; if (rout(5) !== 32'h1000_0005) begin errors++; $display("FAIL alu_r5 got %h exp %h", rout(5), 32'h1000_0005); end
    checks++; if (flushed_out !== 1'b1) begin errors++; $display("FAIL alu_flushed got %b exp 1", flushed_out); end
    // Nothing is accepted here: the registers hold and the PC still advances.
    in_valid = 1'b0; dest_value = 32'h9999; flushed_in = 1'b0; next_pc = 32'h84;
    tick();
    checks++; if (rout(3) !== 32'h1234) begin errors++; $display("FAIL hold_r3 got %h exp %h", rout(3), 32'h1234); end
    checks++; if (flushed_out !== 1'b1) begin errors++; $display("FAIL hold_flushed got %b exp 1", flushed_out); end
    checks++; if (rout(15) !== 32'h84) begin errors++; $display("FAIL hold_pc got %h exp %h", rout(15), 32'h84); end
  endtask

  task automatic test_pc_write();
    in_valid = 1'b1; is_store = 1'b0; dest_reg = 4'd15; dest_value = 32'h200;
    has_upper = 1'b1; upper_value = 32'h55; flags_in = 4'b0000; next_pc = 32'h90;
    tick();
    checks++; if (rout(15) !== 32'h200) begin errors++; $display("FAIL pcw_pc got %h exp %h", rout(15), 32'h200); end
    checks++; if (rout(14) !== 32'h87FF_FFFF) begin errors++; $display("FAIL pcw_flags got %h exp %h", rout(14), 32'h87FF_FFFF); end
    // The upper half would land on the PC, so it is dropped.
    dest_reg = 4'd14; dest_value = 32'hCAFE; upper_value = 32'h77; next_pc = 32'h94;
    tick();
    checks++; if (rout(14) !== 32'hCAFE) begin errors++; $display("FAIL flagw_r14 got %h exp %h", rout(14), 32'hCAFE); end
    checks++; if (rout(15) !== 32'h94) begin errors++; $display("FAIL flagw_pc got %h exp %h", rout(15), 32'h94); end
    // The upper half targets Flags, so it replaces the flag merge.
    dest_reg = 4'd13; dest_value = 32'h13; upper_value = 32'h66; next_pc = 32'h98;
    tick();
    checks++; if (rout(13) !== 32'h13) begin errors++; $display("FAIL upflag_r13 got %h exp %h", rout(13), 32'h13); end
    checks++; if (rout(14) !== 32'h66) begin errors++; $display("FAIL upflag_r14 got %h exp %h", rout(14), 32'h66); end
    in_valid = 1'b0; has_upper = 1'b0;
  endtask

  task automatic test_store_addr();
    drive_store(4'd2, 32'h8, 32'hDEAD);
    flags_in = 4'b0101; next_pc = 32'hA0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL st_ready got %b exp 1", in_ready); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL st_no_bypass got %b exp 0", mem_req); end
    tick();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL st_req got %b exp 1", mem_req); end
    checks++; if (mem_addr !== 32'h108) begin errors++; $display("FAIL st_addr got %h exp %h", mem_addr, 32'h108); end
    checks++; if (mem_data !== 32'hDEAD) begin errors++; $display("FAIL st_data got %h exp %h", mem_data, 32'hDEAD); end
    checks++; if (sb_empty !== 1'b0) begin errors++; $display("FAIL st_sb_empty got %b exp 0", sb_empty); end
    checks++; if (rout(2) !== 32'h100) begin errors++; $display("FAIL st_r2 got %h exp %h", rout(2), 32'h100); end
    checks++; if (rout(3) !== 32'h1000_0003) begin errors++; $display("FAIL st_r3 got %h exp %h", rout(3), 32'h1000_0003); end
    checks++; if (rout(14) !== 32'hAFFF_FFFF) begin errors++; $display("FAIL st_flags got %h exp %h", rout(14), 32'hAFFF_FFFF); end
    checks++; if (rout(15) !== 32'hA0) begin errors++; $display("FAIL st_pc got %h exp %h", rout(15), 32'hA0); end
    // PC-relative store: the base register reads as pc_in.
    drive_store(4'd15, 32'h4, 32'hBEEF);
    pc_in = 32'h40;
    tick();
    checks++; if (mem_addr !== 32'h108) begin errors++; $display("FAIL st_head_stable got %h exp %h", mem_addr, 32'h108); end
    in_valid = 1'b0; mem_ack = 1'b1;
    tick();
    checks++; if (mem_addr !== 32'h44) begin errors++; $display("FAIL st_pc_addr got %h exp %h", mem_addr, 32'h44); end
    checks++; if (mem_data !== 32'hBEEF) begin errors++; $display("FAIL st_pc_data got %h exp %h", mem_data, 32'hBEEF); end
    tick();
    checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL st_drained got %b exp 1", sb_empty); end
    // An ack while nothing is requested must not disturb the count.
    tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL st_idle_ack got %b exp 0", mem_req); end
    mem_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    mem_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_store(4'd1, 32'(4 * k), 32'(32'hD0 + k));
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got %b exp 1", k, in_ready); end
      tick();
    end
    drive_store(4'd1, 32'h10, 32'hD4);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got %b exp 0", in_ready); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    #1;
    checks++; if (mem_addr !== 32'h1004) begin errors++; $display("FAIL b2b_pop_addr got %h exp %h", mem_addr, 32'h1004); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_after_pop_ready got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL b2b_req%0d got %b exp 1", j, mem_req); end
      checks++; if (mem_addr !== 32'(32'h1004 + 4 * j)) begin errors++; $display("FAIL b2b_addr%0d got %h exp %h", j, mem_addr, 32'(32'h1004 + 4 * j)); end
      checks++; if (mem_data !== 32'(32'hD1 + j)) begin errors++; $display("FAIL b2b_data%0d got %h exp %h", j, mem_data, 32'(32'hD1 + j)); end
      mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got %b exp 1", sb_empty); end
  endtask

  task automatic test_combine();
    logic [31:0] exp_addr [3];
    logic [31:0] exp_data [3];
    int          n;
`ifdef WRITE_COMBINE_EN
    n = 2;
    exp_addr[0] = 32'h500; exp_data[0] = 32'h9;
    exp_addr[1] = 32'h300; exp_data[1] = 32'h2;
    exp_addr[2] = 32'h0;   exp_data[2] = 32'h0;
`else
    n = 3;
    exp_addr[0] = 32'h500; exp_data[0] = 32'h9;
    exp_addr[1] = 32'h300; exp_data[1] = 32'h1;
    exp_addr[2] = 32'h300; exp_data[2] = 32'h2;
`endif
    mem_ack = 1'b0;
    drive_store(4'd2, 32'h400, 32'h9); tick();
    drive_store(4'd2, 32'h200, 32'h1); tick();
    drive_store(4'd2, 32'h200, 32'h2); tick();
    in_valid = 1'b0;
    for (int j = 0; j < n; j++) begin
      checks++; if (mem_addr !== exp_addr[j]) begin errors++; $display("FAIL wc_addr%0d got %h exp %h", j, mem_addr, exp_addr[j]); end
      checks++; if (mem_data !== exp_data[j]) begin errors++; $display("FAIL wc_data%0d got %h exp %h", j, mem_data, exp_data[j]); end
      mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL wc_empty got %b exp 1", sb_empty); end
  endtask

  task automatic test_reset_mid_drain();
    mem_ack = 1'b0;
    flushed_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive_store(4'd1, 32'(4 * k), 32'(32'hE0 + k));
      tick();
    end
    in_valid = 1'b0;
    mem_ack = 1'b1;
    tick();
    // Three entries remain and draining is in progress.
    reset = 1'b1;
    tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rmd_req got %b exp 0", mem_req); end
    checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL rmd_empty got %b exp 1", sb_empty); end
    checks++; if (regs_out !== '0) begin errors++; $display("FAIL rmd_regs got %h exp 0", regs_out); end
    checks++; if (flushed_out !== 1'b0) begin errors++; $display("FAIL rmd_flushed got %b exp 0", flushed_out); end
    reset = 1'b0;
    mem_ack = 1'b0;
    tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rmd_after_req got %b exp 0", mem_req); end
    drive_store(4'd2, 32'h8, 32'h77);
    tick();
    in_valid = 1'b0;
    checks++; if (mem_addr !== 32'h108) begin errors++; $display("FAIL rmd_fresh_addr got %h exp %h", mem_addr, 32'h108); end
    checks++; if (mem_data !== 32'h77) begin errors++; $display("FAIL rmd_fresh_data got %h exp %h", mem_data, 32'h77); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rin[i] = 32'h1000_0000 + 32'(i);
    rin[0]  = 32'h5;
    rin[1]  = 32'h1000;
    rin[2]  = 32'h100;
    rin[14] = 32'hFFFF_FFFF;
    reset = 1'b1; in_valid = 1'b0; is_store = 1'b0; dest_reg = '0;
    dest_value = '0; has_upper = 1'b0; upper_value = '0; adjustment = '0;
    flags_in = '0; pc_in = '0; next_pc = '0; flushed_in = 1'b0; mem_ack = 1'b0;

    test_reset();
    test_alu();
    test_pc_write();
    test_store_addr();
    test_back_to_back();
    test_combine();
    test_reset_mid_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_buffered_write
`default_nettype wire
